// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, tick-paced debounce per bit,
// and registered press / release / long-press pulses, all synchronous to clk.
module button_debounce #(
  parameter int WIDTH        = 2,
  parameter int PRESCALE     = 1024,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] button_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released,
  output logic [WIDTH-1:0] long_press,
  output logic             tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam int SW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(LONG_TICKS);

  logic [PW-1:0]           presc_q, presc_d;
  logic [WIDTH-1:0]        sync1_q, sync1_d;
  logic [WIDTH-1:0]        sync2_q, sync2_d;
  logic [WIDTH-1:0][SW-1:0] stable_q, stable_d;
  logic [WIDTH-1:0][HW-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]        level_q, level_d;
  logic [WIDTH-1:0]        pressed_q, pressed_d;
  logic [WIDTH-1:0]        released_q, released_d;
  logic [WIDTH-1:0]        long_q, long_d;

  // Prescaler reset value is 0, so tick is low right after reset.
  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d    = tick ? '0 : presc_q + PW'(1);
    sync1_d    = button_in;
    sync2_d    = sync1_q;
    stable_d   = stable_q;
    hold_d     = hold_q;
    level_d    = level_q;
    pressed_d  = '0;
    released_d = '0;
    long_d     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Any agreeing sample restarts the run of disagreeing ticks.
      if (tick) begin
        if (sync2_q[i] == level_q[i]) begin
          stable_d[i] = '0;
        end else if (stable_q[i] == STABLE_LAST) begin
          stable_d[i]   = '0;
          level_d[i]    = sync2_q[i];
          pressed_d[i]  = sync2_q[i];
          released_d[i] = ~sync2_q[i];
        end else begin
          stable_d[i] = stable_q[i] + SW'(1);
        end
      end
      // Hold counter saturates, so long_press fires once per press.
      if (!level_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && (hold_q[i] != HOLD_MAX)) begin
        hold_d[i] = hold_q[i] + HW'(1);
        long_d[i] = (hold_q[i] == HOLD_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      hold_q     <= '0;
      level_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      long_q     <= '0;
    end else begin
      presc_q    <= presc_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      hold_q     <= hold_d;
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      long_q     <= long_d;
    end
  end

  assign level      = level_q;
  assign pressed    = pressed_q;
  assign released   = released_q;
  assign long_press = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with a small prescale: directed scenarios plus
// random button activity, all compared against a tick-level behavioural model.
module tb_button_debounce;

  localparam int P = 4;
  localparam int S = 3;
  localparam int L = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] button_in = 2'b00;
  logic [1:0] level, pressed, released, long_press;
  logic       tick;

  int checks = 0;
  int errors = 0;

  button_debounce #(
    .WIDTH(2), .PRESCALE(P), .STABLE_TICKS(S), .LONG_TICKS(L)
  ) dut (
    .clk(clk), .reset(reset), .button_in(button_in), .level(level),
    .pressed(pressed), .released(released), .long_press(long_press), .tick(tick)
  );

  always #5 clk = ~clk;

  // Behavioural model: counts cycles since reset for the tick grid, delays the
  // raw input two edges, and flips a level after S consecutive disagreeing ticks.
  int         m_cyc;
  int         m_ticks;
  int         m_run [2];
  int         m_rise_tick [2];
  logic [1:0] m_d1, m_d2, m_samp;
  logic [1:0] m_level, m_pressed, m_released, m_long;
  logic       m_tick;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_cyc = 0; m_ticks = 0; m_d1 = 0; m_d2 = 0;
        m_level = 0; m_pressed = 0; m_released = 0; m_long = 0; m_tick = 0;
        for (int i = 0; i < 2; i++) begin m_run[i] = 0; m_rise_tick[i] = -1000; end
      end else begin
        m_samp = m_d2;
        m_pressed = 0; m_released = 0; m_long = 0;
        if ((m_cyc % P) == P - 1) begin
          m_ticks++;
          for (int i = 0; i < 2; i++) begin
            if (m_level[i] && (m_ticks - m_rise_tick[i] == L)) m_long[i] = 1'b1;
            if (m_samp[i] == m_level[i]) m_run[i] = 0;
            else begin
              m_run[i]++;
              if (m_run[i] == S) begin
                m_run[i] = 0;
                m_level[i] = m_samp[i];
                if (m_samp[i]) begin m_pressed[i] = 1'b1; m_rise_tick[i] = m_ticks; end
                else m_released[i] = 1'b1;
              end
            end
          end
        end
        m_d2 = m_d1;
        m_d1 = button_in;
        m_cyc++;
        m_tick = ((m_cyc % P) == P - 1);
      end
    end
  end

  wire [8:0] dut_vec = {level, pressed, released, long_press, tick};
  wire [8:0] exp_vec = {m_level, m_pressed, m_released, m_long, m_tick};

  task automatic test_reset();
    @(negedge clk); reset = 1'b1; button_in = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 9'b0) begin errors++; $display("FAIL reset_state got %b exp %b", dut_vec, 9'b0); end
    @(negedge clk); reset = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      checks++;
      if (tick !== ((k % P) == P - 1)) begin errors++; $display("FAIL idle_tick k=%0d got %b", k, tick); end
      checks++;
      if ({level, pressed, released, long_press} !== 8'b0) begin
        errors++; $display("FAIL idle_outputs k=%0d got %b exp 0", k, {level, pressed, released, long_press});
      end
    end
  endtask

  task automatic test_step();
    int first, npress, nrel;
    first = 0; npress = 0; nrel = 0;
    @(negedge clk); button_in = 2'b01;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL step_model got %b exp %b", dut_vec, exp_vec); end
      if (level[0] && first == 0) first = k;
      if (pressed[0]) npress++;
      if (released[0]) nrel++;
      checks++;
      if ({level[1], pressed[1], released[1]} !== 3'b0) begin
        errors++; $display("FAIL step_bit1 got %b exp 000", {level[1], pressed[1], released[1]});
      end
    end
    checks++;
    if (first < 11 || first > 14) begin errors++; $display("FAIL step_latency got %0d exp 11..14", first); end
    checks++;
    if (npress != 1) begin errors++; $display("FAIL step_pressed_count got %0d exp 1", npress); end
    checks++;
    if (nrel != 0) begin errors++; $display("FAIL step_released_count got %0d exp 0", nrel); end
    @(negedge clk); button_in = 2'b00;
    nrel = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL release_model got %b exp %b", dut_vec, exp_vec); end
      if (released[0]) nrel++;
    end
    checks++;
    if (nrel != 1) begin errors++; $display("FAIL release_count got %0d exp 1", nrel); end
  endtask

  // Bounce patterns start in a tick cycle so the sampling phase is known.
  task automatic test_glitch();
    int found, npulse, npress, first;
    found = 0;
    for (int k = 0; k < 2 * P && found == 0; k++) begin
      @(posedge clk); #1;
      if (m_tick) found = 1;
    end
    checks++;
    if (found == 0) begin errors++; $display("FAIL glitch_align got no tick exp tick"); end
    npulse = 0;
    @(negedge clk); button_in = 2'b01;
    for (int k = 1; k <= 38; k++) begin
      if (k == 9) begin @(negedge clk); button_in = 2'b00; end
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL glitch_model got %b exp %b", dut_vec, exp_vec); end
      if (level[0] || pressed[0] || released[0]) npulse++;
    end
    checks++;
    if (npulse != 0) begin errors++; $display("FAIL glitch_ignored got %0d events exp 0", npulse); end
    found = 0;
    for (int k = 0; k < 2 * P && found == 0; k++) begin
      @(posedge clk); #1;
      if (m_tick) found = 1;
    end
    npress = 0; first = 0;
    @(negedge clk); button_in = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      if (k == 7) begin @(negedge clk); button_in = 2'b00; end
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL bounce_model got %b exp %b", dut_vec, exp_vec); end
      if (pressed[0]) npress++;
    end
    @(negedge clk); button_in = 2'b01;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL bounce_model got %b exp %b", dut_vec, exp_vec); end
      if (pressed[0]) begin npress++; if (first == 0) first = k; end
    end
    checks++;
    if (npress != 1) begin errors++; $display("FAIL bounce_pressed_count got %0d exp 1", npress); end
    checks++;
    if (first < 11 || first > 14) begin errors++; $display("FAIL bounce_latency got %0d exp 11..14", first); end
    @(negedge clk); button_in = 2'b00;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL bounce_release got %b exp %b", dut_vec, exp_vec); end
    end
  endtask

  task automatic test_long_press();
    int rise, lp_at, nlp, nrel;
    rise = 0; lp_at = 0; nlp = 0; nrel = 0;
    @(negedge clk); button_in = 2'b10;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL long_model got %b exp %b", dut_vec, exp_vec); end
      if (level[1] && rise == 0) rise = k;
      if (long_press[1]) begin nlp++; lp_at = k; end
    end
    checks++;
    if (nlp != 1) begin errors++; $display("FAIL long_count got %0d exp 1", nlp); end
    checks++;
    if (lp_at - rise != L * P) begin errors++; $display("FAIL long_delay got %0d exp %0d", lp_at - rise, L * P); end
    @(negedge clk); button_in = 2'b00;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL long_release got %b exp %b", dut_vec, exp_vec); end
      if (released[1]) nrel++;
    end
    checks++;
    if (nrel != 1) begin errors++; $display("FAIL long_released_count got %0d exp 1", nrel); end
    nlp = 0;
    @(negedge clk); button_in = 2'b10;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL long_rearm got %b exp %b", dut_vec, exp_vec); end
      if (long_press[1]) nlp++;
    end
    checks++;
    if (nlp != 1) begin errors++; $display("FAIL long_rearm_count got %0d exp 1", nlp); end
    @(negedge clk); button_in = 2'b00;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL long_idle got %b exp %b", dut_vec, exp_vec); end
    end
  endtask

  task automatic test_simultaneous();
    int nboth, nsplit;
    nboth = 0; nsplit = 0;
    @(negedge clk); button_in = 2'b11;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL simul_model got %b exp %b", dut_vec, exp_vec); end
      if (pressed == 2'b11) nboth++;
      if (pressed == 2'b01 || pressed == 2'b10) nsplit++;
    end
    checks++;
    if (nboth != 1 || nsplit != 0) begin
      errors++; $display("FAIL simul_pressed got both=%0d split=%0d exp both=1 split=0", nboth, nsplit);
    end
  endtask

  task automatic test_reset_mid();
    int first, nrel;
    first = 0; nrel = 0;
    checks++;
    if (level[0] !== 1'b1) begin errors++; $display("FAIL midreset_pre got %b exp 1", level[0]); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dut_vec !== 9'b0) begin errors++; $display("FAIL midreset_clear got %b exp 0", dut_vec); end
    @(negedge clk); reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL midreset_model got %b exp %b", dut_vec, exp_vec); end
      if (pressed[0] && first == 0) first = k;
      if (released != 2'b00) nrel++;
    end
    checks++;
    if (first < 11 || first > 14) begin errors++; $display("FAIL midreset_latency got %0d exp 11..14", first); end
    checks++;
    if (nrel != 0) begin errors++; $display("FAIL midreset_released got %0d exp 0", nrel); end
  endtask

  task automatic test_random();
    int remain;
    remain = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      if (remain == 0) begin
        button_in = 2'($urandom_range(0, 3));
        remain = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 160) : $urandom_range(1, 20);
      end
      remain--;
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL random_model k=%0d got %b exp %b", k, dut_vec, exp_vec); end
    end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_long_press();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Synchronizes and debounces the raw FPGA push buttons, then emits clean level and one-cycle event pulses.
- Sits directly upstream of the reset/boot support logic, which consumes these events to re-arm reset and boot.
- Uses one clock domain and a clock-enable prescaler instead of derived slow clocks, so all outputs are synchronous to clk.

Parameters:
- WIDTH, 2: number of independent buttons (bit 0 = reset button, bit 1 = boot button).
- PRESCALE, 1024: clk cycles per sample tick; must be >= 2.
- STABLE_TICKS, 10: consecutive disagreeing ticks required to change the debounced level; must be >= 1.
- LONG_TICKS, 1000: ticks a button must stay debounced-high before long_press fires; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- button_in  input  WIDTH  raw asynchronous button inputs, active-high.
- level  output  WIDTH  debounced button state.
- pressed  output  WIDTH  one-clk pulse when level goes 0->1.
- released  output  WIDTH  one-clk pulse when level goes 1->0.
- long_press  output  WIDTH  one-clk pulse after LONG_TICKS of continuous level=1.
- tick  output  1  sample strobe, exported for debug and for downstream use.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All state changes only on rising clk.
- Reset: on any edge with reset=1, clear the prescaler, both synchronizer stages, stable counters, hold counters, level, pressed, released, long_press and tick to 0. This applies mid-operation too.
- Prescaler:
  - Counter runs 0..PRESCALE-1 and wraps to 0.
  - tick=1 exactly while the counter equals PRESCALE-1, giving one cycle in every PRESCALE.
  - The first tick after reset falls in the PRESCALE-th cycle.
- Synchronizer: two flops per bit (sync1<=button_in, sync2<=sync1) every clk, independent of tick.
- Debounce, per bit, on edges where tick=1 only:
  - If sync2==level, the stable counter goes to 0.
  - Otherwise, if counter==STABLE_TICKS-1: level<=sync2 and counter<=0.
  - Otherwise the counter increments.
  - Any agreeing tick restarts the count, so glitches shorter than STABLE_TICKS ticks never change level.
- Latency:
  - A clean input step changes level on edge N after the step, where 2+(STABLE_TICKS-1)*PRESCALE+1 <= N <= 2+STABLE_TICKS*PRESCALE.
  - N depends on prescaler phase.
- Events:
  - pressed[i] and released[i] are registered.
  - Each is high for exactly the one cycle in which level[i] first shows its new value.
  - They are never both high for the same bit.
  - Bits are fully independent; simultaneous events on different bits are all reported in the same cycle.
- Long press, per bit:
  - The hold counter clears whenever level=0.
  - While level=1, it increments on each tick, saturating at LONG_TICKS.
  - long_press[i] pulses for one cycle on the tick edge where the counter reaches LONG_TICKS.
  - It fires at most once per press and rearms only after level returns to 0.
- Counter widths: sized by $clog2 of the parameter (+1 where needed to hold the terminal value). No counter ever wraps except the prescaler.
- Button held through reset:
  - After reset deasserts, level=0 and no pulses occur immediately.
  - pressed fires once the normal debounce latency elapses.

Test Plan (PRESCALE=4, STABLE_TICKS=3, LONG_TICKS=8, WIDTH=2):
- Reset, then hold inputs at 0 for 100 cycles -> tick pulses every 4th cycle starting cycle 4; level, pressed, released, long_press stay 0.
- Step button_in[0] 0->1 and hold -> level[0] rises on the 11th–14th edge after the step; pressed[0] is high exactly 1 cycle; released[0] stays 0; bit 1 is unaffected.
- Glitch: button_in[0]=1 for 8 cycles (at most 2 ticks), then 0 -> level[0] never changes and no pulses occur. Repeat with bounce (1 for 6, 0 for 2, 1 held) -> exactly one pressed pulse, with latency counted from the last edge.
- Hold button_in[1]=1 for 200 cycles -> long_press[1] pulses once, 8 ticks (32 cycles) after level[1] rose, with no repeat. Release -> released[1] one pulse. Press again -> long_press rearms and fires again.
- Press both buttons on the same cycle -> pressed=2'b11 for one cycle simultaneously.
- Assert reset for 1 cycle while level[0]=1 with the button still held -> all outputs 0 next cycle; pressed[0] re-fires after 11–14 cycles; no released pulse is generated by the reset.
